// File: rtl/sum_display_mux.sv
// sum_display_mux: accepts a 5-bit sum, converts it to BCD by 5-step double-dabble,
// and drives a time-multiplexed two-digit seven-segment display.
module sum_display_mux #(
  parameter int REFRESH_COUNT = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       sum_valid,
  output logic       sum_ready,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       busy
);
  localparam int CW = $clog2(REFRESH_COUNT);
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  state_t state, state_nx;
  logic [4:0] shift_q;
  logic [7:0] bcd_q, bcd_nx;
  logic [2:0] step_q;
  logic [3:0] tens_q, ones_q, digit;
  logic [CW-1:0] cnt_q;
  logic idx_q, shown_q, accept, last_step, wrap;
  logic [6:0] enc;
  assign sum_ready = state != CONV;
  assign busy = state == CONV;
  assign accept = sum_valid && sum_ready;
  assign last_step = state == CONV && step_q == 3'd4;
  assign wrap = cnt_q == CW'(REFRESH_COUNT - 1);
  // tens never exceeds 3 during conversion, so its top adjusted bit is always zero
  assign bcd_nx = {3'(bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4]),
                   bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0],
                   shift_q[4]};
  always_comb begin
    state_nx = accept ? CONV : last_step ? SHOW : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift_q <= '0;
      bcd_q <= '0;
      step_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      cnt_q <= '0;
      idx_q <= 1'b0;
      shown_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        shift_q <= sum_in;
        bcd_q <= '0;
        step_q <= '0;
      end else if (state == CONV) begin
        shift_q <= {shift_q[3:0], 1'b0};
        bcd_q <= bcd_nx;
        step_q <= step_q + 3'd1;
      end
      if (last_step) begin
        tens_q <= bcd_nx[7:4];
        ones_q <= bcd_nx[3:0];
        shown_q <= 1'b1;
      end
      if (shown_q) begin
        cnt_q <= wrap ? '0 : cnt_q + CW'(1);
        if (wrap) idx_q <= ~idx_q;
      end
    end
  end
  assign digit = idx_q ? tens_q : ones_q;
  always_comb begin
    case (digit)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  end
  // a zero tens digit is blanked but keeps its time slot
  assign seg = (!shown_q || (idx_q && tens_q == 4'd0)) ? 7'd0 : enc;
  assign dig_sel = shown_q ? {idx_q, ~idx_q} : 2'b00;
endmodule

// File: doc/sum_display_mux.md
# sum_display_mux

Output stage that sits directly downstream of the 4-bit adder. It accepts the adder's 5-bit sum (0..31) over a valid/ready handshake and converts it to two BCD digits with a sequential 5-step double-dabble. It then drives a time-multiplexed, two-digit seven-segment display, refreshing continuously until a new sum is accepted.

## Interface
- REFRESH_COUNT, default 10_000: clock cycles each digit is lit before the display switches to the other digit; legal range ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- sum_in  input  5  adder result; sampled only on a handshake.
- sum_valid  input  1  sum_in holds a new value.
- sum_ready  output  1  block can accept a sum this cycle.
- seg  output  7  segment drive, active-high; seg[0]=a … seg[6]=g.
- dig_sel  output  2  digit enable, active-high; [0]=ones, [1]=tens.
- busy  output  1  high while a conversion is in progress.

## Operation
- FSM states: IDLE, CONV, SHOW. Reset enters IDLE.
- sum_ready is 1 in IDLE and SHOW, and 0 in CONV. busy is 1 exactly in CONV.
- Handshake:
  - A sum is accepted on any edge where sum_valid=1 and sum_ready=1.
  - On acceptance: sum_in is latched into the shift register, the BCD scratch register is cleared, step count = 0, and the FSM goes to CONV.
  - sum_valid while sum_ready=0 is ignored. The producer must hold the value until it is accepted.
- CONV, one step per cycle, 5 steps:
  - Any BCD nibble ≥ 5 gets +3.
  - Then {bcd, shift} shifts left by 1 (shift MSB into bcd LSB).
  - After step 5, tens/ones are copied into the display registers, the shown flag is set, and the FSM goes to SHOW.
- Arithmetic: inputs 0..31 map to tens 0..3 and ones 0..9. 31 displays "31". No saturation or error case.
- Display:
  - Active whenever shown=1, in every state including CONV. During CONV the previous value stays visible.
  - A refresh counter counts 0..REFRESH_COUNT-1. At wrap it toggles the digit index (starts at ones).
  - dig_sel = 2'b01 for ones and 2'b10 for tens. Exactly one bit is high when shown=1; both are 0 when shown=0.
- Segment encoding for digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- Leading-zero blanking: tens digit 0 drives seg=0, with dig_sel[1] still asserted in its slot.
- seg=0 whenever shown=0.
- Reset, including mid-CONV:
  - FSM goes to IDLE and shown=0.
  - Display registers, refresh counter, digit index, shift/BCD registers and step counter all clear to 0.
  - Output values after reset: seg=0, dig_sel=0, sum_ready=1, busy=0.
  - The in-flight conversion is discarded.

## Timing
- Handshake edge = edge 0. CONV occupies cycles 1..5. Display registers update on edge 5. The new digits are visible from cycle 6.
- Throughput: one sum per 6 cycles (accept cycle + 5 CONV cycles).
- sum_ready falls the cycle after acceptance and rises the cycle after the last CONV step.
- A sum can be accepted in the first SHOW cycle.
- seg and dig_sel are combinational from registered state (display registers, digit index, shown). There is no extra output register stage.
- The refresh counter free-runs once shown=1. A new conversion does not reset it.
- The digit index changes on the edge where the counter wraps from REFRESH_COUNT-1 to 0.

## Test plan
- Reset: assert rst for 2 cycles with sum_valid=1 → seg=0, dig_sel=0, sum_ready=1, busy=0; no acceptance during reset.
- Single conversion (REFRESH_COUNT=4): send sum_in=11 → busy high for exactly 5 cycles. From cycle 6, the ones slot shows dig_sel=01/seg=06, then the tens slot shows dig_sel=10/seg=06; the two alternate every 4 cycles.
- Range ends: sum_in=30 → tens seg=4F, ones seg=3F. sum_in=0 → tens slot seg=0 (blanked), ones seg=3F. sum_in=31 → 4F / 06.
- Back-pressure: hold sum_valid=1 with sum_in=7, then change sum_in=25 during CONV → 7 is displayed; 25 is accepted in the first SHOW cycle and displayed (tens 5B, ones 6D) 6 cycles after its acceptance. The display shows 7 throughout the second CONV.
- Reset mid-CONV: accept 19, assert rst at CONV step 3 → next cycle IDLE, seg=0, dig_sel=0, sum_ready=1; a following sum of 4 displays 66 in the ones slot with tens blanked.
